// File: rtl/mctp_pcievdm_rx_mbox.sv
// -----------------------------------------------------------------------------
// mctp_pcievdm_rx_mbox
//   Receive mailbox between an AVMM writer and a BMC reader for MCTP-over-
//   PCIe-VDM packets. The writer streams DWORDs into a packet buffer through the
//   DATA register (bursts allowed), then writes the packet length to COMMIT.
//   A matching commit hands the buffer to the BMC, and the buffer stays frozen
//   until the BMC releases it. A burst that stalls for too long is dropped.
//
//   Optional feature: define MCTP_RX_MBOX_DBG_EN to build saturating packet
//   and drop counters on dbg_sts. Without it dbg_sts is tied to 0.
//
// Ports
//   clk, reset_n           sole clock, synchronous active-low reset
//   pulse_1us              one-cycle 1 us tick feeding the burst stall timer
//   avmm_slv_*             AVMM slave: word address 0 STATUS (RO),
//                          1 COMMIT (WO), 2 DATA (WO, burst)
//   bmc_pkt_avail/len      committed packet held and its length in DWORDs
//   bmc_rd_en/addr/data    BMC buffer read port, data one cycle after enable
//   bmc_pkt_release        hands the buffer back to the writer
//   dbg_sts                {pkt_cnt, drop_cnt} debug counters
// -----------------------------------------------------------------------------
module mctp_pcievdm_rx_mbox #(
   parameter int ADDR_WIDTH = 20,
   parameter int BRST_WIDTH = 9,
   parameter int BUF_DEPTH  = 64,
   parameter int TIMEOUT_US = 255,
   localparam int PW        = $clog2(BUF_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  pulse_1us,
   input  logic [ADDR_WIDTH-1:0] avmm_slv_addr,
   input  logic                  avmm_slv_write,
   input  logic                  avmm_slv_read,
   input  logic [BRST_WIDTH-1:0] avmm_slv_burstcnt,
   input  logic [31:0]           avmm_slv_wrdata,
   output logic [31:0]           avmm_slv_rddata,
   output logic                  avmm_slv_rddvld,
   output logic                  avmm_slv_waitreq,
   output logic                  bmc_pkt_avail,
   output logic [PW-1:0]         bmc_pkt_len,
   input  logic                  bmc_rd_en,
   input  logic [PW-1:0]         bmc_rd_addr,
   output logic [31:0]           bmc_rd_data,
   input  logic                  bmc_pkt_release,
   output logic [31:0]           dbg_sts
);

   localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int SW = (TIMEOUT_US > 1) ? $clog2(TIMEOUT_US + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_BURST, S_HELD} state_t;

   state_t                state_q, state_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic                  ovf_q, ovf_d;
   logic [BRST_WIDTH-1:0] rem_q, rem_d;
   logic [SW-1:0]         stall_q, stall_d;
   logic                  avail_q, avail_d;
   logic [PW-1:0]         len_q, len_d;
   logic [31:0]           rddata_q, rddata_d;
   logic                  rddvld_q, rddvld_d;
   logic [31:0]           rd_data_q, rd_data_d;

   logic [31:0]           mem [BUF_DEPTH];

   logic                  is_status, is_commit, is_data;
   logic                  wr_stall, wr_acc, rd_acc, beat;
   logic                  mem_we, commit_evt, drop_evt;
   logic [PW-1:0]         commit_len;
   logic [BRST_WIDTH-1:0] rem_first;
   logic [31:0]           status;

   assign is_status  = (avmm_slv_addr == ADDR_WIDTH'(0));
   assign is_commit  = (avmm_slv_addr == ADDR_WIDTH'(1));
   assign is_data    = (avmm_slv_addr == ADDR_WIDTH'(2));
   assign commit_len = avmm_slv_wrdata[PW-1:0];

   // While the packet is held, anything that could touch the buffer or its
   // length is back-pressured; other writes and all reads still complete.
   assign wr_stall = (state_q == S_HELD) && avmm_slv_write && (is_commit || is_data);
   assign wr_acc   = avmm_slv_write && !wr_stall;
   // A write beside a read wins; the read is dropped without rddvld.
   assign rd_acc   = avmm_slv_read && !avmm_slv_write;
   // Inside a burst the address is ignored: every accepted write is payload.
   assign beat     = wr_acc && ((state_q == S_BURST) || ((state_q == S_IDLE) && is_data));
   // A burstcount of 0 behaves as a single beat.
   assign rem_first = (avmm_slv_burstcnt == '0) ? '0 : avmm_slv_burstcnt - BRST_WIDTH'(1);

   assign avmm_slv_waitreq = wr_stall;
   assign avmm_slv_rddata  = rddata_q;
   assign avmm_slv_rddvld  = rddvld_q;
   assign bmc_pkt_avail    = avail_q;
   assign bmc_pkt_len      = len_q;
   assign bmc_rd_data      = rd_data_q;

   always_comb begin
      status           = '0;
      status[0]        = (state_q == S_HELD);
      status[1]        = ovf_q;
      status[2]        = (state_q == S_BURST);
      status[8 +: PW]  = wr_ptr_q;
   end

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      ovf_d      = ovf_q;
      rem_d      = rem_q;
      stall_d    = stall_q;
      avail_d    = avail_q;
      len_d      = len_q;
      mem_we     = 1'b0;
      commit_evt = 1'b0;
      drop_evt   = 1'b0;

      // A beat arriving with the buffer full is lost; the overflow flag
      // guarantees the following commit is refused.
      if (beat) begin
         if (wr_ptr_q == PW'(BUF_DEPTH)) begin
            ovf_d = 1'b1;
         end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (beat) begin
               rem_d   = rem_first;
               stall_d = '0;
               if (rem_first != '0) state_d = S_BURST;
            end else if (wr_acc && is_commit) begin
               if ((commit_len == wr_ptr_q) && (commit_len != '0) && !ovf_q) begin
                  state_d    = S_HELD;
                  avail_d    = 1'b1;
                  len_d      = commit_len;
                  commit_evt = 1'b1;
               end else begin
                  wr_ptr_d = '0;
                  ovf_d    = 1'b0;
                  drop_evt = 1'b1;
               end
            end
         end
         S_BURST: begin
            if (beat) begin
               rem_d   = rem_q - BRST_WIDTH'(1);
               stall_d = '0;
               if (rem_q == BRST_WIDTH'(1)) state_d = S_IDLE;
            end else if (pulse_1us) begin
               if (stall_q == SW'(TIMEOUT_US - 1)) begin
                  state_d  = S_IDLE;
                  wr_ptr_d = '0;
                  ovf_d    = 1'b0;
                  stall_d  = '0;
                  drop_evt = 1'b1;
               end else begin
                  stall_d = stall_q + SW'(1);
               end
            end
         end
         S_HELD: begin
            if (bmc_pkt_release) begin
               state_d  = S_IDLE;
               wr_ptr_d = '0;
               avail_d  = 1'b0;
               len_d    = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rddvld_d  = rd_acc;
      rddata_d  = (rd_acc && is_status) ? status : 32'h0;
      rd_data_d = rd_data_q;
      if (bmc_rd_en) begin
         rd_data_d = (bmc_rd_addr < PW'(BUF_DEPTH)) ? mem[bmc_rd_addr[AW-1:0]] : 32'h0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         wr_ptr_q  <= '0;
         ovf_q     <= 1'b0;
         rem_q     <= '0;
         stall_q   <= '0;
         avail_q   <= 1'b0;
         len_q     <= '0;
         rddata_q  <= '0;
         rddvld_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         ovf_q     <= ovf_d;
         rem_q     <= rem_d;
         stall_q   <= stall_d;
         avail_q   <= avail_d;
         len_q     <= len_d;
         rddata_q  <= rddata_d;
         rddvld_q  <= rddvld_d;
         rd_data_q <= rd_data_d;
      end
   end

   // Buffer storage carries no reset; validity is tracked by wr_ptr.
   always_ff @(posedge clk) begin
      if (reset_n && mem_we) mem[wr_ptr_q[AW-1:0]] <= avmm_slv_wrdata;
   end

`ifdef MCTP_RX_MBOX_DBG_EN
   logic [15:0] pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;

   always_comb begin
      pkt_cnt_d  = pkt_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (commit_evt && (pkt_cnt_q != 16'hFFFF))  pkt_cnt_d  = pkt_cnt_q + 16'd1;
      if (drop_evt   && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pkt_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         pkt_cnt_q  <= pkt_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign dbg_sts = {pkt_cnt_q, drop_cnt_q};
`else
   logic evt_unused;
   assign evt_unused = commit_evt | drop_evt;
   assign dbg_sts    = '0;
`endif

endmodule

// File: tb/tb_mctp_pcievdm_rx_mbox.sv
// -----------------------------------------------------------------------------
// tb_mctp_pcievdm_rx_mbox
//   Directed plus randomized bench. The reference model keeps the packet
//   buffer as a plain array with a fill count and flags, and predicts STATUS,
//   commit outcome, buffer contents and debug counters from the mailbox rules.
// -----------------------------------------------------------------------------
module tb_mctp_pcievdm_rx_mbox;
   localparam int AWD   = 20;
   localparam int BW    = 9;
   localparam int DEPTH = 64;
   localparam int TO    = 255;
   localparam int PW    = $clog2(DEPTH + 1);

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic           pulse_1us = 1'b0;
   logic [AWD-1:0] avmm_slv_addr = '0;
   logic           avmm_slv_write = 1'b0;
   logic           avmm_slv_read = 1'b0;
   logic [BW-1:0]  avmm_slv_burstcnt = '0;
   logic [31:0]    avmm_slv_wrdata = '0;
   logic [31:0]    avmm_slv_rddata;
   logic           avmm_slv_rddvld;
   logic           avmm_slv_waitreq;
   logic           bmc_pkt_avail;
   logic [PW-1:0]  bmc_pkt_len;
   logic           bmc_rd_en = 1'b0;
   logic [PW-1:0]  bmc_rd_addr = '0;
   logic [31:0]    bmc_rd_data;
   logic           bmc_pkt_release = 1'b0;
   logic [31:0]    dbg_sts;

   always #5 clk = ~clk;

   mctp_pcievdm_rx_mbox #(
      .ADDR_WIDTH(AWD), .BRST_WIDTH(BW), .BUF_DEPTH(DEPTH), .TIMEOUT_US(TO)
   ) dut (
      .clk(clk), .reset_n(reset_n), .pulse_1us(pulse_1us),
      .avmm_slv_addr(avmm_slv_addr), .avmm_slv_write(avmm_slv_write),
      .avmm_slv_read(avmm_slv_read), .avmm_slv_burstcnt(avmm_slv_burstcnt),
      .avmm_slv_wrdata(avmm_slv_wrdata), .avmm_slv_rddata(avmm_slv_rddata),
      .avmm_slv_rddvld(avmm_slv_rddvld), .avmm_slv_waitreq(avmm_slv_waitreq),
      .bmc_pkt_avail(bmc_pkt_avail), .bmc_pkt_len(bmc_pkt_len),
      .bmc_rd_en(bmc_rd_en), .bmc_rd_addr(bmc_rd_addr), .bmc_rd_data(bmc_rd_data),
      .bmc_pkt_release(bmc_pkt_release), .dbg_sts(dbg_sts)
   );

   int errs = 0;
   int checks = 0;

   // reference model
   logic [31:0] mbuf [DEPTH];
   int          mptr = 0;
   bit          movf = 1'b0;
   bit          mheld = 1'b0;
   bit          mburst = 1'b0;
   int          mlen = 0;
   int          mpkt = 0;
   int          mdrop = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic void m_beat(input logic [31:0] d);
      if (mptr < DEPTH) begin
         mbuf[mptr] = d;
         mptr++;
      end else begin
         movf = 1'b1;
      end
   endfunction

   function automatic void m_commit(input int len);
      int l;
      l = len % (1 << PW);
      if (l == mptr && l != 0 && !movf) begin
         mheld = 1'b1;
         mlen  = l;
         if (mpkt < 65535) mpkt++;
      end else begin
         mptr = 0;
         movf = 1'b0;
         if (mdrop < 65535) mdrop++;
      end
   endfunction

   function automatic logic [31:0] exp_status();
      logic [31:0] s;
      s = 32'h0;
      s[0] = mheld;
      s[1] = movf;
      s[2] = mburst;
      s[8 +: PW] = PW'(mptr);
      return s;
   endfunction

   function automatic logic [31:0] exp_dbg();
`ifdef MCTP_RX_MBOX_DBG_EN
      return {16'(mpkt), 16'(mdrop)};
`else
      return 32'h0;
`endif
   endfunction

   // One AVMM write, held until waitreq drops (bounded).
   task automatic wr(input int a, input logic [31:0] d, input int bc);
      int n;
      n = 0;
      avmm_slv_addr     = AWD'(a);
      avmm_slv_wrdata   = d;
      avmm_slv_burstcnt = BW'(bc);
      avmm_slv_write    = 1'b1;
      #1;
      while (avmm_slv_waitreq && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) begin
         checks++;
         errs++;
         $error("FAIL wr_wait observed=stalled expected=accepted addr=%0d", a);
      end
      step();
      avmm_slv_write = 1'b0;
   endtask

   task automatic rd(input int a, output logic [31:0] d);
      avmm_slv_addr = AWD'(a);
      avmm_slv_read = 1'b1;
      step();
      avmm_slv_read = 1'b0;
      chk("rddvld", 32'(avmm_slv_rddvld), 32'h1);
      d = avmm_slv_rddata;
   endtask

   task automatic bmc_rd(input int idx, output logic [31:0] d);
      bmc_rd_addr = PW'(idx);
      bmc_rd_en   = 1'b1;
      step();
      bmc_rd_en   = 1'b0;
      d = bmc_rd_data;
   endtask

   task automatic chk_status(input string tag);
      logic [31:0] s;
      rd(0, s);
      chk(tag, s, exp_status());
   endtask

   // k of the n beats of a burst; later beats use random addresses since the
   // address is irrelevant inside a burst.
   task automatic beats(input int n, input int k, input logic [31:0] base, input bit rnd);
      logic [31:0] d;
      for (int i = 0; i < k; i++) begin
         d = rnd ? $urandom : base + 32'(i);
         wr((i == 0) ? 2 : int'($urandom_range(0, 7)), d, n);
         m_beat(d);
      end
      mburst = (k < n) && (n > 1);
   endtask

   task automatic commit(input int len);
      wr(1, 32'(len), 1);
      m_commit(len);
      chk("pkt_avail", 32'(bmc_pkt_avail), 32'(mheld));
      if (mheld) chk("pkt_len", 32'(bmc_pkt_len), 32'(mlen));
   endtask

   task automatic release_pkt();
      bmc_pkt_release = 1'b1;
      step();
      bmc_pkt_release = 1'b0;
      if (mheld) begin
         mheld = 1'b0;
         mptr  = 0;
      end
      chk("avail_after_release", 32'(bmc_pkt_avail), 32'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [31:0] x;
      int n, len, idx;

      // reset state
      repeat (3) step();
      chk("rst_rddata", avmm_slv_rddata, 32'h0);
      chk("rst_rddvld", 32'(avmm_slv_rddvld), 32'h0);
      chk("rst_waitreq", 32'(avmm_slv_waitreq), 32'h0);
      chk("rst_avail", 32'(bmc_pkt_avail), 32'h0);
      chk("rst_len", 32'(bmc_pkt_len), 32'h0);
      chk("rst_rd_data", bmc_rd_data, 32'h0);
      chk("rst_dbg", dbg_sts, 32'h0);
      reset_n = 1'b1;
      step();
      chk_status("idle_status");

      // 16-beat packet committed and read back by the BMC
      beats(16, 16, 32'h1000, 1'b0);
      commit(16);
      bmc_rd(5, d);
      chk("bmc_rd_5", d, 32'h1005);
      chk_status("held_status");
      chk("dbg_commit", dbg_sts, exp_dbg());

      // DATA write while held stalls until release, then lands at index 0
      x = 32'hCAFE_0001;
      avmm_slv_addr = AWD'(2); avmm_slv_wrdata = x; avmm_slv_burstcnt = BW'(1);
      avmm_slv_write = 1'b1;
      #1;
      chk("held_waitreq_0", 32'(avmm_slv_waitreq), 32'h1);
      step();
      chk("held_waitreq_1", 32'(avmm_slv_waitreq), 32'h1);
      bmc_rd(0, d);
      chk("held_frozen", d, 32'h1000);
      chk("held_waitreq_2", 32'(avmm_slv_waitreq), 32'h1);
      bmc_pkt_release = 1'b1;
      step();
      bmc_pkt_release = 1'b0;
      mheld = 1'b0; mptr = 0;
      chk("rel_avail", 32'(bmc_pkt_avail), 32'h0);
      chk("rel_waitreq", 32'(avmm_slv_waitreq), 32'h0);
      step();
      avmm_slv_write = 1'b0;
      m_beat(x);
      commit(1);
      bmc_rd(0, d);
      chk("stalled_wr_idx0", d, x);
      release_pkt();

      // short commit is dropped
      beats(16, 16, 32'h2000, 1'b0);
      commit(15);
      chk_status("drop_status");
      chk("dbg_drop", dbg_sts, exp_dbg());

      // burstcount 0 is a single beat; release while not held is ignored
      wr(2, 32'h3333_0000, 0);
      m_beat(32'h3333_0000);
      chk_status("bc0_status");
      release_pkt();
      chk_status("idle_release_ignored");
      commit(1);
      bmc_rd(0, d);
      chk("bc0_data", d, 32'h3333_0000);
      release_pkt();

      // write and read together: write taken, no read data
      avmm_slv_addr = AWD'(2); avmm_slv_wrdata = 32'h4444_0000;
      avmm_slv_burstcnt = BW'(1); avmm_slv_write = 1'b1; avmm_slv_read = 1'b1;
      step();
      avmm_slv_write = 1'b0; avmm_slv_read = 1'b0;
      chk("wr_rd_no_dvld", 32'(avmm_slv_rddvld), 32'h0);
      m_beat(32'h4444_0000);
      chk_status("wr_rd_status");
      commit(1);
      release_pkt();

      // unmapped and write-only reads return 0
      rd(int'($urandom_range(3, 1000)), d);
      chk("rd_unmapped", d, 32'h0);
      rd(2, d);
      chk("rd_data_reg", d, 32'h0);

      // overflow: 65 beats into 64 entries, COMMIT 64 refused
      beats(65, 65, 32'h5000, 1'b0);
      chk_status("ovf_status");
      commit(64);
      chk_status("ovf_drop_status");

      // mid-burst stall timeout
      beats(8, 3, 32'h6000, 1'b0);
      chk_status("burst_status");
      for (int i = 0; i < TO - 1; i++) begin
         pulse_1us = 1'b1; step(); pulse_1us = 1'b0; step();
      end
      chk_status("stall_pre_timeout");
      pulse_1us = 1'b1; step(); pulse_1us = 1'b0;
      mburst = 1'b0; mptr = 0; movf = 1'b0;
      if (mdrop < 65535) mdrop++;
      chk_status("timeout_status");
      chk("dbg_timeout", dbg_sts, exp_dbg());

      // reset mid-burst discards everything
      beats(8, 3, 32'h7000, 1'b0);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      mptr = 0; movf = 1'b0; mburst = 1'b0; mheld = 1'b0; mpkt = 0; mdrop = 0;
      chk("rst_mid_avail", 32'(bmc_pkt_avail), 32'h0);
      chk_status("rst_mid_status");
      chk("rst_mid_dbg", dbg_sts, exp_dbg());
      wr(2, 32'h7777_0000, 1);
      m_beat(32'h7777_0000);
      commit(1);
      bmc_rd(0, d);
      chk("rst_mid_idx0", d, 32'h7777_0000);
      release_pkt();

      // randomized packets with matching and mismatching commits
      for (int it = 0; it < 10; it++) begin
         n = int'($urandom_range(1, 20));
         beats(n, n, 32'h0, 1'b1);
         case ($urandom_range(0, 2))
            0: len = n;
            1: len = n - 1;
            default: len = n + 1;
         endcase
         commit(len);
         chk_status("rnd_status");
         if (mheld) begin
            for (int j = 0; j < 3; j++) begin
               idx = int'($urandom_range(0, n - 1));
               bmc_rd(idx, d);
               chk("rnd_bmc_data", d, mbuf[idx]);
            end
            bmc_rd(DEPTH + int'($urandom_range(0, 63)), d);
            chk("rnd_bmc_oob", d, 32'h0);
            release_pkt();
         end
         chk("rnd_dbg", dbg_sts, exp_dbg());
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/mctp_pcievdm_rx_mbox.md
MCTP_PCIEVDM_RX_MBOX -- requirements
Module: mctp_pcievdm_rx_mbox

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 20: AVMM slave word-address width.
REQ-002 SHALL provide parameter BRST_WIDTH, default 9: burstcount width.
REQ-003 SHALL provide parameter BUF_DEPTH, default 64: packet buffer depth in DWORDs (max 255); PW = clog2(BUF_DEPTH+1).
REQ-004 SHALL provide parameter TIMEOUT_US, default 255: mid-burst stall limit in microseconds.
REQ-005 SHALL provide ports (clock and reset first):
 clk  in  1  sole clock
 reset_n  in  1  synchronous active-low reset
 pulse_1us  in  1  one-cycle 1 us tick
 avmm_slv_addr  in  ADDR_WIDTH  word address
 avmm_slv_write / avmm_slv_read  in  1  requests
 avmm_slv_burstcnt  in  BRST_WIDTH  write burst length
 avmm_slv_wrdata  in  32  write data
 avmm_slv_rddata  out  32  read data
 avmm_slv_rddvld  out  1  read data valid
 avmm_slv_waitreq  out  1  stall
 bmc_pkt_avail  out  1  committed packet held
 bmc_pkt_len  out  PW  committed length, DWORDs
 bmc_rd_en  in  1  buffer read strobe
 bmc_rd_addr  in  PW  buffer DWORD index
 bmc_rd_data  out  32  buffer read data
 bmc_pkt_release  in  1  return buffer to writer
 dbg_sts  out  32  debug counters

Function
REQ-006 SHALL decode word addresses: 0 STATUS (RO), 1 COMMIT (WO), 2 DATA (WO, burst); other addresses: writes ignored, reads return 0.
REQ-007 SHALL implement FSM IDLE, BURST, HELD.
REQ-008 IDLE, DATA write beat: store at wr_ptr, wr_ptr+1; remaining = burstcnt-1 (burstcnt 0 treated as 1); remaining>0 -> BURST.
REQ-009 BURST: every write beat is a DATA beat regardless of address; last beat -> IDLE.
REQ-010 Beat with wr_ptr == BUF_DEPTH SHALL be discarded, wr_ptr unchanged, overflow flag set.
REQ-011 IDLE, COMMIT write, len = wrdata[PW-1:0]: len == wr_ptr, len != 0, overflow clear -> HELD, bmc_pkt_avail=1 and bmc_pkt_len=len next cycle; otherwise drop: wr_ptr=0, overflow cleared, drop event.
REQ-012 HELD: avmm_slv_waitreq=1 for DATA and COMMIT writes; buffer contents frozen.
REQ-013 HELD plus bmc_pkt_release -> IDLE, wr_ptr=0, bmc_pkt_avail=0 next cycle; release outside HELD ignored.
REQ-014 BURST: stall counter clears on each beat, increments on pulse_1us; reaching TIMEOUT_US -> IDLE, wr_ptr=0, overflow cleared, drop event.
REQ-015 Reads SHALL never stall; avmm_slv_rddvld one cycle after read, any state.
REQ-016 STATUS: [0] HELD, [1] overflow, [2] BURST, [8+PW-1:8] wr_ptr, rest 0.
REQ-017 Simultaneous write and read: write processed, read ignored, no rddvld.
REQ-018 bmc_rd_data SHALL be registered, valid one cycle after bmc_rd_en; bmc_rd_addr >= BUF_DEPTH returns 0.
REQ-019 Packet commit and drop events SHALL each pulse one cycle internally for counters.

Reset
REQ-020 reset_n low at a clk edge: FSM IDLE, wr_ptr, overflow, stall counter, counters 0; all outputs 0; mid-burst or held data discarded.

Configuration
REQ-021 Macro MCTP_RX_MBOX_DBG_EN defined: dbg_sts = {pkt_cnt[15:0], drop_cnt[15:0]}, both saturating at 0xFFFF; undefined: counters not built, dbg_sts = 0; all other behaviour identical.

Verification
REQ-022 16-beat DATA burst 0x1000+i, COMMIT 16 -> bmc_pkt_avail=1, bmc_pkt_len=16; bmc_rd_addr=5 -> bmc_rd_data 0x1005 next cycle.
REQ-023 16 beats, COMMIT 15 -> no avail, STATUS wr_ptr 0, dbg_sts[15:0]=1 with DBG_EN.
REQ-024 HELD, DATA write -> waitreq high until bmc_pkt_release; write then lands at index 0.
REQ-025 BUF_DEPTH=64, 65 beats -> STATUS[1]=1; COMMIT 64 -> dropped, bmc_pkt_avail stays 0.
REQ-026 Burst 8, stop after 3 beats, 255 pulse_1us -> STATUS[2]=0, wr_ptr 0, drop_cnt 1.
REQ-027 reset_n low mid-burst -> STATUS reads 0, bmc_pkt_avail 0, next DATA beat stored at index 0.
